subneg_mem_arbiter: RTL and testbench
=====================================

Name: subneg_mem_arbiter

Overview:
- Sequences and shares the external SRAM bus (8-bit address latch, SRAM with active-low OE/WE, output latch) between two requesters: the SUBNEG core (cpu port) and a program loader (ldr port).
- Each granted request becomes a complete multi-cycle latch/read or latch/write bus sequence, ending in a one-cycle ack.
- Sits between the core/loader and the uo_out/uio pins.

Parameters:
- DW, 8, data and address width. Address and data share the bus.
- OUT_ADDR, 255, write address that is redirected to the output latch.
- OUT_ENABLE, 1, 1 = redirect writes to OUT_ADDR; 0 = OUT_ADDR is ordinary SRAM.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  arbiter enable; 0 = release bus to the board
- cpu_req  in  1  core request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  DW  address
- cpu_wdata  in  DW  write data
- cpu_rdata  out  DW  read data
- cpu_ack  out  1  one-cycle completion pulse
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack  same as the cpu_* ports, for the loader
- bus_in  in  DW  shared bus input (uio_in)
- bus_out  out  DW  shared bus drive value (uio_out)
- bus_oe  out  1  1 = drive bus (fans out to all uio_oe bits)
- mem_latch_clk  out  1  address latch clock; rising edge captures bus
- mem_oe_n  out  1  SRAM output enable, active low
- mem_we_n  out  1  SRAM write enable, active low
- out_latch_clk  out  1  output latch clock
- busy  out  1  high when state is not IDLE
- grant_ldr  out  1  current/last owner; 1 = loader

Behaviour:
- All outputs are registered. Per-state values below hold while in that state.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - bus_out=0, bus_oe=1, mem_latch_clk=0, mem_oe_n=1, mem_we_n=1, out_latch_clk=0.
  - Both acks=0, both rdata=0, busy=0, grant_ldr=1, so the cpu wins the first tie.
  - Reset during a write raises mem_we_n immediately. No ack is issued.
- IDLE:
  - Strobes are inactive. bus_oe=en.
  - With en=1, req is sampled each edge.
  - Winner selection: a single requester wins. If both request, the port not granted last wins (round-robin).
  - On a grant: capture we/addr/wdata, set grant_ldr, go to ADDR.
  - With en=0: no grant, bus_oe=0.
  - en is ignored outside IDLE; an in-flight transaction always completes.
- ADDR: bus_out=addr, bus_oe=1, mem_latch_clk=0.
- LATCH: mem_latch_clk=1. Next state is RD_OE if we=0, else WR_DATA.
- Read path:
  - RD_OE: bus_oe=0, mem_oe_n=0.
  - RD_SAMPLE: same outputs. bus_in is captured into the owner's rdata on the edge leaving this state.
  - DONE (turnaround): mem_oe_n=1, bus_oe stays 0. bus_oe returns to 1 only in IDLE.
- Write path:
  - WR_DATA: bus_out=wdata, bus_oe=1, mem_latch_clk=0.
  - WR_STROBE: mem_we_n=0. If OUT_ENABLE and addr==OUT_ADDR, out_latch_clk=1 instead and mem_we_n stays 1.
  - WR_HOLD: mem_we_n=1, out_latch_clk=0, bus_out still wdata.
  - DONE: bus_out still wdata.
- DONE: owner's ack=1 for exactly one cycle, then IDLE.
- Latency, counted from the edge that samples req in IDLE:
  - Read: ack high during the 5th cycle after that edge.
  - Write: ack high during the 6th cycle after that edge.
- Back-to-back transactions:
  - A req still high in the IDLE cycle after DONE starts a new transaction. This allows back-to-back transfers.
  - Minimum gap between transactions: one IDLE cycle.
- rdata holds its value until the next read by the same port. It is unaffected by the other port's transfers.
- Requester rules:
  - Requester inputs are latched at grant; changing them mid-transaction has no effect.
  - Dropping req before ack does not abort the transaction.
- Invariants:
  - mem_oe_n=0 never coincides with bus_oe=1.
  - mem_we_n=0 never coincides with mem_oe_n=0.
  - At most one ack is high per cycle.

Test Plan:
- Reset mid-write: assert rst_n=0 during WR_STROBE -> mem_we_n=1 immediately; all outputs at reset values; no ack.
- cpu read of addr 0x10, SRAM model returns 0xA5 -> bus_out=0x10 while latch rises; mem_oe_n low for 2 cycles; cpu_rdata=0xA5; cpu_ack on 5th cycle; ldr_rdata unchanged.
- ldr write 0x3C to 0x20 -> mem_we_n low exactly one cycle with bus_out=0x3C stable from the cycle before through the cycle after; ldr_ack on 6th cycle; SRAM[0x20]=0x3C.
- cpu write 0x7F to 255, OUT_ENABLE=1 -> out_latch_clk one-cycle pulse, mem_we_n never low, SRAM[255] unchanged. With OUT_ENABLE=0 -> SRAM[255]=0x7F.
- Both requests held continuously for 4 transactions -> grants alternate cpu, ldr, cpu, ldr; IDLE cycle between each; no cycle with both acks high.
- en=0 in IDLE with cpu_req=1 -> bus_oe=0, no grant. en=0 asserted mid-read -> that read completes with ack, then no new grant.

Source files
------------

// File: rtl/subneg_mem_arbiter_if.sv
// rtl/subneg_mem_arbiter_if.sv - requester handshake bundle (req/we/addr/wdata in, rdata/ack out)
interface subneg_mem_arbiter_if #(
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  // Requester side: raises req with command, waits for ack
  modport master (output req, we, addr, wdata, input rdata, ack);
  // Arbiter side
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/subneg_mem_arbiter.sv
// rtl/subneg_mem_arbiter.sv - shares the latched SRAM bus between the SUBNEG core and the loader
module subneg_mem_arbiter #(
  parameter int          DW         = 8,
  parameter int unsigned OUT_ADDR   = 255,
  parameter bit          OUT_ENABLE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  subneg_mem_arbiter_if.slave cpu,
  subneg_mem_arbiter_if.slave ldr,
  input  logic [DW-1:0]       bus_in,
  output logic [DW-1:0]       bus_out,
  output logic                bus_oe,
  output logic                mem_latch_clk,
  output logic                mem_oe_n,
  output logic                mem_we_n,
  output logic                out_latch_clk,
  output logic                busy,
  output logic                grant_ldr
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    LATCH,
    RD_OE,
    RD_SAMPLE,
    WR_DATA,
    WR_STROBE,
    WR_HOLD,
    DONE
  } state_t;

  localparam logic [DW-1:0] OUT_A = DW'(OUT_ADDR);

  state_t        state;
  logic          we_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          pick_ldr;
  logic          is_out;

  // Loader wins when it is the only requester, or on a tie when the cpu was granted last
  assign pick_ldr = ldr.req && (!cpu.req || !grant_ldr);
  // Writes to the output latch address strobe the latch instead of the SRAM
  assign is_out   = OUT_ENABLE && (addr_q == OUT_A);

  // Sequencer: every output is set on the edge entering the state it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bus_out       <= '0;
      bus_oe        <= 1'b1;
      mem_latch_clk <= 1'b0;
      mem_oe_n      <= 1'b1;
      mem_we_n      <= 1'b1;
      out_latch_clk <= 1'b0;
      busy          <= 1'b0;
      grant_ldr     <= 1'b1;
      cpu.ack       <= 1'b0;
      ldr.ack       <= 1'b0;
      cpu.rdata     <= '0;
      ldr.rdata     <= '0;
    end else begin
      cpu.ack <= 1'b0;
      ldr.ack <= 1'b0;
      case (state)
        IDLE: begin
          bus_oe        <= en;
          mem_latch_clk <= 1'b0;
          mem_oe_n      <= 1'b1;
          mem_we_n      <= 1'b1;
          out_latch_clk <= 1'b0;
          if (en && (cpu.req || ldr.req)) begin
            grant_ldr <= pick_ldr;
            we_q      <= pick_ldr ? ldr.we    : cpu.we;
            addr_q    <= pick_ldr ? ldr.addr  : cpu.addr;
            wdata_q   <= pick_ldr ? ldr.wdata : cpu.wdata;
            bus_out   <= pick_ldr ? ldr.addr  : cpu.addr;
            bus_oe    <= 1'b1;
            busy      <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          mem_latch_clk <= 1'b1;
          state         <= LATCH;
        end
        LATCH: begin
          mem_latch_clk <= 1'b0;
          if (!we_q) begin
            bus_oe   <= 1'b0;
            mem_oe_n <= 1'b0;
            state    <= RD_OE;
          end else begin
            bus_out <= wdata_q;
            state   <= WR_DATA;
          end
        end
        RD_OE: begin
          state <= RD_SAMPLE;
        end
        RD_SAMPLE: begin
          mem_oe_n <= 1'b1;
          if (grant_ldr) begin
            ldr.rdata <= bus_in;
            ldr.ack   <= 1'b1;
          end else begin
            cpu.rdata <= bus_in;
            cpu.ack   <= 1'b1;
          end
          state <= DONE;
        end
        WR_DATA: begin
          if (is_out) out_latch_clk <= 1'b1;
          else        mem_we_n      <= 1'b0;
          state <= WR_STROBE;
        end
        WR_STROBE: begin
          mem_we_n      <= 1'b1;
          out_latch_clk <= 1'b0;
          state         <= WR_HOLD;
        end
        WR_HOLD: begin
          if (grant_ldr) ldr.ack <= 1'b1;
          else           cpu.ack <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy   <= 1'b0;
          bus_oe <= en;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subneg_mem_arbiter.sv
// tb/tb_subneg_mem_arbiter.sv - directed self-checking bench for subneg_mem_arbiter
module tb_subneg_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] bus_in, bus_out;
  logic       bus_oe, mem_latch_clk, mem_oe_n, mem_we_n, out_latch_clk, busy, grant_ldr;

  logic [7:0] bus_in2, bus_out2;
  logic       bus_oe2, mem_latch_clk2, mem_oe_n2, mem_we_n2, out_latch_clk2, busy2, grant_ldr2;

  logic [7:0] sram  [256];
  logic [7:0] sram2 [256];
  logic [7:0] lat_addr  = 8'h00;
  logic [7:0] lat_addr2 = 8'h00;
  logic [7:0] out_q     = 8'h00;

  int errors = 0;
  int checks = 0;

  logic [7:0] t_bus_out [16];
  logic       t_bus_oe [16], t_latch [16], t_oe_n [16], t_we_n [16];
  logic       t_outclk [16], t_cack [16], t_lack [16];

  subneg_mem_arbiter_if #(.DW(8)) cpu_if ();
  subneg_mem_arbiter_if #(.DW(8)) ldr_if ();
  subneg_mem_arbiter_if #(.DW(8)) cpu2_if ();
  subneg_mem_arbiter_if #(.DW(8)) ldr2_if ();

  subneg_mem_arbiter #(.DW(8), .OUT_ADDR(255), .OUT_ENABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cpu(cpu_if), .ldr(ldr_if),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .mem_latch_clk(mem_latch_clk),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .out_latch_clk(out_latch_clk),
    .busy(busy), .grant_ldr(grant_ldr)
  );

  subneg_mem_arbiter #(.DW(8), .OUT_ADDR(255), .OUT_ENABLE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .cpu(cpu2_if), .ldr(ldr2_if),
    .bus_in(bus_in2), .bus_out(bus_out2), .bus_oe(bus_oe2), .mem_latch_clk(mem_latch_clk2),
    .mem_oe_n(mem_oe_n2), .mem_we_n(mem_we_n2), .out_latch_clk(out_latch_clk2),
    .busy(busy2), .grant_ldr(grant_ldr2)
  );

  always #5 clk = ~clk;

  // Board model: address latch, SRAM, output latch
  always @(posedge mem_latch_clk)  lat_addr  = bus_out;
  always @(posedge mem_latch_clk2) lat_addr2 = bus_out2;
  always @(posedge out_latch_clk)  out_q     = bus_out;
  always @(negedge clk) if (!mem_we_n)  sram[lat_addr]   = bus_out;
  always @(negedge clk) if (!mem_we_n2) sram2[lat_addr2] = bus_out2;
  assign bus_in  = mem_oe_n  ? 8'h00 : sram[lat_addr];
  assign bus_in2 = mem_oe_n2 ? 8'h00 : sram2[lat_addr2];

  task automatic run_txn(input bit is_ldr, input bit we, input logic [7:0] a, input logic [7:0] d);
    for (int i = 0; i < 16; i++) begin
      t_bus_out[i] = 8'h00; t_bus_oe[i] = 1'b0; t_latch[i] = 1'b0; t_oe_n[i] = 1'b1;
      t_we_n[i] = 1'b1; t_outclk[i] = 1'b0; t_cack[i] = 1'b0; t_lack[i] = 1'b0;
    end
    @(negedge clk);
    if (is_ldr) begin
      ldr_if.req = 1'b1; ldr_if.we = we; ldr_if.addr = a; ldr_if.wdata = d;
    end else begin
      cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = d;
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      t_bus_out[k] = bus_out; t_bus_oe[k] = bus_oe; t_latch[k] = mem_latch_clk;
      t_oe_n[k] = mem_oe_n; t_we_n[k] = mem_we_n; t_outclk[k] = out_latch_clk;
      t_cack[k] = cpu_if.ack; t_lack[k] = ldr_if.ack;
      checks++;
      if ((!mem_oe_n && bus_oe) || (!mem_we_n && !mem_oe_n) || (cpu_if.ack && ldr_if.ack)) begin
        errors++;
        $display("FAIL invariant cycle %0d: oe_n=%b bus_oe=%b we_n=%b acks=%b%b, required no overlap",
                 k, mem_oe_n, bus_oe, mem_we_n, cpu_if.ack, ldr_if.ack);
      end
      // Inputs change after grant to show they were captured
      if (k == 1) begin
        if (is_ldr) begin ldr_if.addr = ~a; ldr_if.wdata = ~d; ldr_if.we = ~we; end
        else        begin cpu_if.addr = ~a; cpu_if.wdata = ~d; cpu_if.we = ~we; end
      end
      if (cpu_if.ack || ldr_if.ack) begin
        cpu_if.req = 1'b0;
        ldr_if.req = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_out !== 8'h00 || bus_oe !== 1'b1 || mem_latch_clk !== 1'b0 || mem_oe_n !== 1'b1 ||
        mem_we_n !== 1'b1 || out_latch_clk !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: bus_out=%h oe=%b latch=%b oe_n=%b we_n=%b outclk=%b, required 00 1 0 1 1 0",
               bus_out, bus_oe, mem_latch_clk, mem_oe_n, mem_we_n, out_latch_clk);
    end
    checks++;
    if (cpu_if.ack !== 1'b0 || ldr_if.ack !== 1'b0 || cpu_if.rdata !== 8'h00 || ldr_if.rdata !== 8'h00 ||
        busy !== 1'b0 || grant_ldr !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: acks=%b%b rdata=%h/%h busy=%b grant_ldr=%b, required 00 00/00 0 1",
               cpu_if.ack, ldr_if.ack, cpu_if.rdata, ldr_if.rdata, busy, grant_ldr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    int acks;
    @(negedge clk);
    ldr_if.req = 1'b1; ldr_if.we = 1'b1; ldr_if.addr = 8'h30; ldr_if.wdata = 8'h55;
    repeat (4) @(negedge clk);
    checks++;
    if (mem_we_n !== 1'b0) begin
      errors++;
      $display("FAIL midwr_strobe: mem_we_n=%b, required 0 in 4th cycle", mem_we_n);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we_n !== 1'b1 || bus_out !== 8'h00 || bus_oe !== 1'b1 || busy !== 1'b0 ||
        grant_ldr !== 1'b1 || ldr_if.ack !== 1'b0 || ldr_if.rdata !== 8'h00) begin
      errors++;
      $display("FAIL midwr_reset: we_n=%b bus_out=%h oe=%b busy=%b grant=%b ack=%b rdata=%h, required 1 00 1 0 1 0 00",
               mem_we_n, bus_out, bus_oe, busy, grant_ldr, ldr_if.ack, ldr_if.rdata);
    end
    ldr_if.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cpu_if.ack || ldr_if.ack) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL midwr_noack: acks=%0d, required 0", acks);
    end
  endtask

  task automatic test_cpu_read;
    int oe_low, first_ack, lacks;
    sram[8'h10] = 8'hA5;
    run_txn(1'b0, 1'b0, 8'h10, 8'h00);
    checks++;
    if (t_bus_out[1] !== 8'h10 || t_bus_oe[1] !== 1'b1 || t_latch[1] !== 1'b0) begin
      errors++;
      $display("FAIL rd_addr: bus_out=%h oe=%b latch=%b, required 10 1 0", t_bus_out[1], t_bus_oe[1], t_latch[1]);
    end
    checks++;
    if (t_latch[2] !== 1'b1 || t_bus_out[2] !== 8'h10) begin
      errors++;
      $display("FAIL rd_latch: latch=%b bus_out=%h, required 1 10", t_latch[2], t_bus_out[2]);
    end
    oe_low = 0; first_ack = 0; lacks = 0;
    for (int k = 1; k <= 12; k++) begin
      if (!t_oe_n[k]) oe_low++;
      if (t_cack[k] && first_ack == 0) first_ack = k;
      if (t_lack[k]) lacks++;
    end
    checks++;
    if (oe_low !== 2 || t_oe_n[3] !== 1'b0 || t_oe_n[4] !== 1'b0) begin
      errors++;
      $display("FAIL rd_oe: oe_n low %0d cycles (c3=%b c4=%b), required 2 at cycles 3,4", oe_low, t_oe_n[3], t_oe_n[4]);
    end
    checks++;
    if (first_ack !== 5 || lacks !== 0) begin
      errors++;
      $display("FAIL rd_latency: cpu_ack cycle=%0d ldr_acks=%0d, required 5 and 0", first_ack, lacks);
    end
    checks++;
    if (t_bus_oe[5] !== 1'b0 || t_bus_oe[6] !== 1'b1) begin
      errors++;
      $display("FAIL rd_turnaround: bus_oe done=%b idle=%b, required 0 1", t_bus_oe[5], t_bus_oe[6]);
    end
    checks++;
    if (cpu_if.rdata !== 8'hA5 || ldr_if.rdata !== 8'h00) begin
      errors++;
      $display("FAIL rd_data: cpu_rdata=%h ldr_rdata=%h, required A5 00", cpu_if.rdata, ldr_if.rdata);
    end
  endtask

  task automatic test_out_latch;
    int we_low, oc_high, first_ack, we2_low;
    bit got2;
    sram[8'hFF] = 8'h11;
    sram2[8'hFF] = 8'h11;
    run_txn(1'b0, 1'b1, 8'hFF, 8'h7F);
    we_low = 0; oc_high = 0; first_ack = 0;
    for (int k = 1; k <= 12; k++) begin
      if (!t_we_n[k]) we_low++;
      if (t_outclk[k]) oc_high++;
      if (t_cack[k] && first_ack == 0) first_ack = k;
    end
    checks++;
    if (oc_high !== 1 || t_outclk[4] !== 1'b1 || we_low !== 0) begin
      errors++;
      $display("FAIL outl_strobe: outclk high %0d (c4=%b) we_n low %0d, required 1 at cycle 4 and 0", oc_high, t_outclk[4], we_low);
    end
    checks++;
    if (out_q !== 8'h7F || sram[8'hFF] !== 8'h11 || first_ack !== 6) begin
      errors++;
      $display("FAIL outl_result: out=%h sram255=%h ack_cycle=%0d, required 7F 11 6", out_q, sram[8'hFF], first_ack);
    end
    @(negedge clk);
    cpu2_if.req = 1'b1; cpu2_if.we = 1'b1; cpu2_if.addr = 8'hFF; cpu2_if.wdata = 8'h7F;
    we2_low = 0; got2 = 1'b0;
    for (int k = 1; k <= 12 && !got2; k++) begin
      @(negedge clk);
      if (!mem_we_n2) we2_low++;
      if (cpu2_if.ack) begin got2 = 1'b1; cpu2_if.req = 1'b0; end
    end
    cpu2_if.req = 1'b0;
    checks++;
    if (!got2 || we2_low !== 1 || sram2[8'hFF] !== 8'h7F) begin
      errors++;
      $display("FAIL outl_disabled: ack=%b we_n low %0d sram255=%h, required 1 1 7F", got2, we2_low, sram2[8'hFF]);
    end
  endtask

  task automatic test_ldr_write;
    int we_low, first_ack, cacks;
    run_txn(1'b1, 1'b1, 8'h20, 8'h3C);
    we_low = 0; first_ack = 0; cacks = 0;
    for (int k = 1; k <= 12; k++) begin
      if (!t_we_n[k]) we_low++;
      if (t_lack[k] && first_ack == 0) first_ack = k;
      if (t_cack[k]) cacks++;
    end
    checks++;
    if (we_low !== 1 || t_we_n[4] !== 1'b0) begin
      errors++;
      $display("FAIL wr_strobe: we_n low %0d cycles (c4=%b), required 1 at cycle 4", we_low, t_we_n[4]);
    end
    checks++;
    if (t_bus_out[3] !== 8'h3C || t_bus_out[4] !== 8'h3C || t_bus_out[5] !== 8'h3C ||
        !t_bus_oe[3] || !t_bus_oe[4] || !t_bus_oe[5]) begin
      errors++;
      $display("FAIL wr_data: bus_out c3..c5=%h %h %h, required 3C 3C 3C driven", t_bus_out[3], t_bus_out[4], t_bus_out[5]);
    end
    checks++;
    if (first_ack !== 6 || cacks !== 0) begin
      errors++;
      $display("FAIL wr_latency: ldr_ack cycle=%0d cpu_acks=%0d, required 6 and 0", first_ack, cacks);
    end
    checks++;
    if (sram[8'h20] !== 8'h3C || cpu_if.rdata !== 8'hA5 || grant_ldr !== 1'b1) begin
      errors++;
      $display("FAIL wr_result: sram20=%h cpu_rdata=%h grant_ldr=%b, required 3C A5 1", sram[8'h20], cpu_if.rdata, grant_ldr);
    end
  endtask

  task automatic test_round_robin;
    int n, both, idle_bad, prev;
    int seq [4];
    int at [4];
    n = 0; both = 0; idle_bad = 0; prev = -10;
    for (int i = 0; i < 4; i++) begin seq[i] = -1; at[i] = 0; end
    @(negedge clk);
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 8'h20;
    ldr_if.req = 1'b1; ldr_if.we = 1'b0; ldr_if.addr = 8'h10;
    for (int k = 1; k <= 60 && n < 4; k++) begin
      @(negedge clk);
      if (k == prev + 1 && busy) idle_bad++;
      if (cpu_if.ack && ldr_if.ack) both++;
      if (cpu_if.ack || ldr_if.ack) begin
        seq[n] = ldr_if.ack ? 1 : 0;
        at[n] = k;
        n++;
        prev = k;
        if (n == 4) begin cpu_if.req = 1'b0; ldr_if.req = 1'b0; end
      end
    end
    cpu_if.req = 1'b0; ldr_if.req = 1'b0;
    checks++;
    if (n !== 4 || seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 0 || seq[3] !== 1) begin
      errors++;
      $display("FAIL rr_order: count=%0d owners=%0d%0d%0d%0d, required 4 0101", n, seq[0], seq[1], seq[2], seq[3]);
    end
    checks++;
    if (at[0] !== 5 || at[1] - at[0] !== 6 || at[2] - at[1] !== 6 || at[3] - at[2] !== 6) begin
      errors++;
      $display("FAIL rr_spacing: ack cycles %0d %0d %0d %0d, required 5 11 17 23", at[0], at[1], at[2], at[3]);
    end
    checks++;
    if (both !== 0 || idle_bad !== 0) begin
      errors++;
      $display("FAIL rr_idle: both_ack=%0d missing_idle=%0d, required 0 0", both, idle_bad);
    end
    checks++;
    if (cpu_if.rdata !== 8'h3C || ldr_if.rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rr_data: cpu_rdata=%h ldr_rdata=%h, required 3C A5", cpu_if.rdata, ldr_if.rdata);
    end
  endtask

  task automatic test_enable;
    int busy_seen, acks, first_ack;
    @(negedge clk);
    en = 1'b0;
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 8'h10;
    busy_seen = 0; acks = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (cpu_if.ack || ldr_if.ack) acks++;
    end
    checks++;
    if (bus_oe !== 1'b0 || busy_seen !== 0 || acks !== 0) begin
      errors++;
      $display("FAIL en_off: bus_oe=%b busy_cycles=%0d acks=%0d, required 0 0 0", bus_oe, busy_seen, acks);
    end
    en = 1'b1;
    acks = 0; first_ack = 0; busy_seen = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) en = 1'b0;
      if (cpu_if.ack) begin acks++; if (first_ack == 0) first_ack = k; end
      if (k >= 6 && busy) busy_seen++;
    end
    checks++;
    if (first_ack !== 5 || acks !== 1 || busy_seen !== 0) begin
      errors++;
      $display("FAIL en_midread: ack cycle=%0d acks=%0d busy_after=%0d, required 5 1 0", first_ack, acks, busy_seen);
    end
    checks++;
    if (bus_oe !== 1'b0 || cpu_if.rdata !== 8'hA5) begin
      errors++;
      $display("FAIL en_release: bus_oe=%b cpu_rdata=%h, required 0 A5", bus_oe, cpu_if.rdata);
    end
    cpu_if.req = 1'b0;
    en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin sram[i] = 8'h00; sram2[i] = 8'h00; end
    en = 1'b1;
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = 8'h00; cpu_if.wdata = 8'h00;
    ldr_if.req = 1'b0; ldr_if.we = 1'b0; ldr_if.addr = 8'h00; ldr_if.wdata = 8'h00;
    cpu2_if.req = 1'b0; cpu2_if.we = 1'b0; cpu2_if.addr = 8'h00; cpu2_if.wdata = 8'h00;
    ldr2_if.req = 1'b0; ldr2_if.we = 1'b0; ldr2_if.addr = 8'h00; ldr2_if.wdata = 8'h00;
    test_reset;
    test_reset_mid_write;
    test_cpu_read;
    test_out_latch;
    test_ldr_write;
    test_round_robin;
    test_enable;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
